// File: rtl/arm6_dmem_ctrl_if.sv
// Core-side ram_* port and SRAM-bank port of the arm6 data memory controller.
// The slave modport is the controller; master is the core plus SRAM bank around it.
interface arm6_dmem_ctrl_if #(
  parameter int unsigned MEM_AW = 12
) ();

  logic [31:0]       ram_addr;
  logic              ram_cen;
  logic              ram_wen;
  logic [3:0]        ram_flag;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              ram_abort;
  logic              cpu_en;

  logic              sram_ce;
  logic              sram_we;
  logic [3:0]        sram_be;
  logic [MEM_AW-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  modport master (
    output ram_addr, ram_cen, ram_wen, ram_flag, ram_wdata, sram_rdata,
    input  ram_rdata, ram_abort, cpu_en,
    input  sram_ce, sram_we, sram_be, sram_addr, sram_wdata
  );

  modport slave (
    input  ram_addr, ram_cen, ram_wen, ram_flag, ram_wdata, sram_rdata,
    output ram_rdata, ram_abort, cpu_en,
    output sram_ce, sram_we, sram_be, sram_addr, sram_wdata
  );

endinterface

// File: rtl/arm6_dmem_ctrl.sv
// Data-side memory controller: range/lane-checks one core access at a time,
// inserts wait states, strobes a 1-cycle-latency SRAM and stalls the core meanwhile.
module arm6_dmem_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int unsigned MEM_AW      = 12,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  arm6_dmem_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_INIT =
    CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  // 33-bit bank bounds so a bank ending at 2^32 cannot wrap
  localparam logic [32:0] BANK_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] BANK_HI = BANK_LO + (33'd4 << MEM_AW);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_RDATA  = 3'd3;
  localparam logic [2:0] ST_ABORT  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0]        state_q,      state_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic              wen_q,        wen_d;
  logic              sram_ce_q,    sram_ce_d;
  logic              sram_we_q,    sram_we_d;
  logic [3:0]        sram_be_q,    sram_be_d;
  logic [MEM_AW-1:0] sram_addr_q,  sram_addr_d;
  logic [31:0]       sram_wdata_q, sram_wdata_d;
  logic [31:0]       ram_rdata_q,  ram_rdata_d;
  logic              ram_abort_q,  ram_abort_d;

  logic [32:0]       addr33_c;
  logic              in_range_c;
  logic              flag_ok_c;
  logic              legal_c;
  logic [MEM_AW-1:0] word_addr_c;

  // Legality of the request currently on the core port
  always_comb begin
    addr33_c    = {1'b0, bus.ram_addr};
    in_range_c  = (addr33_c >= BANK_LO) && (addr33_c < BANK_HI);
    word_addr_c = MEM_AW'((bus.ram_addr - BASE_ADDR) >> 2);
    case (bus.ram_flag)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: flag_ok_c = 1'b1;
      default:                   flag_ok_c = 1'b0;
    endcase
    legal_c = in_range_c && flag_ok_c;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wen_d        = wen_q;
    sram_ce_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_be_d    = sram_be_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    ram_rdata_d  = ram_rdata_q;
    ram_abort_d  = ram_abort_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.ram_cen) begin
          wen_d        = bus.ram_wen;
          sram_be_d    = bus.ram_flag;
          sram_addr_d  = word_addr_c;
          sram_wdata_d = bus.ram_wdata;
          if (!legal_c) begin
            state_d = ST_ABORT;
          end else if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d   = ST_ACCESS;
            sram_ce_d = 1'b1;
            sram_we_d = bus.ram_wen;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d   = ST_ACCESS;
          sram_ce_d = 1'b1;
          sram_we_d = wen_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACCESS: begin
        state_d = wen_q ? ST_DONE : ST_RDATA;
      end
      ST_RDATA: begin
        // full word returned; lane selection is the core's job
        ram_rdata_d = bus.sram_rdata;
        state_d     = ST_DONE;
      end
      ST_ABORT: begin
        ram_abort_d = 1'b1;
        ram_rdata_d = '0;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        ram_abort_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wen_q        <= 1'b0;
      sram_ce_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_be_q    <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      ram_rdata_q  <= '0;
      ram_abort_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wen_q        <= wen_d;
      sram_ce_q    <= sram_ce_d;
      sram_we_q    <= sram_we_d;
      sram_be_q    <= sram_be_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      ram_rdata_q  <= ram_rdata_d;
      ram_abort_q  <= ram_abort_d;
    end
  end

  // Core is released only when idle without a request, or for the single DONE cycle
  assign bus.cpu_en     = ((state_q == ST_IDLE) && !bus.ram_cen) || (state_q == ST_DONE);
  assign bus.ram_rdata  = ram_rdata_q;
  assign bus.ram_abort  = ram_abort_q;
  assign bus.sram_ce    = sram_ce_q;
  assign bus.sram_we    = sram_we_q;
  assign bus.sram_be    = sram_be_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;

endmodule
